// File: rtl/vga_text_pkg.sv
// Shared definitions for the 40x30 text display front end.
//   - geometry defaults (COLS/ROWS/AW), clear fill byte
//   - control-code constants understood by vram_text_writer
//   - writer FSM state encoding
package vga_text_pkg;

    localparam int          COLS_DEF = 40;
    localparam int          ROWS_DEF = 30;
    localparam int          AW_DEF   = 11;
    localparam logic [7:0]  BLANK_CH = 8'h20;

    localparam logic [7:0]  CH_BS = 8'h08;
    localparam logic [7:0]  CH_LF = 8'h0A;
    localparam logic [7:0]  CH_FF = 8'h0C;
    localparam logic [7:0]  CH_CR = 8'h0D;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_CLR_SCREEN = 2'd1,
        ST_CLR_LINE   = 2'd2
    } state_e;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

endpackage

// File: rtl/vram_text_writer_if.sv
// Byte stream input plus VRAM write port of the text writer.
//   in_data/in_valid/in_ready : byte source handshake
//   vram_waddr/wdata/we       : display VRAM write port
// master = byte source / VRAM-side observer, slave = vram_text_writer.
interface vram_text_writer_if #(parameter int AW = 11);
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] vram_waddr;
    logic [7:0]    vram_wdata;
    logic          vram_we;

    modport master (output in_data, output in_valid, input in_ready,
                    input vram_waddr, input vram_wdata, input vram_we);
    modport slave  (input in_data, input in_valid, output in_ready,
                    output vram_waddr, output vram_wdata, output vram_we);
endinterface

// File: rtl/vram_fill_seq.sv
// Address counter + write strobe for a block fill of len words from
// start_addr. Comes out of reset already running a fill of INIT_LEN
// words from 0, which gives the power-on screen clear for free.
//   start/start_addr/len : load a new fill (len >= 1)
//   we/addr              : current fill write, one address per cycle
//   last                 : current write is the final one
module vram_fill_seq #(
    parameter int AW       = 11,
    parameter int INIT_LEN = 1200
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic [AW:0]   len,
    output logic          we,
    output logic [AW-1:0] addr,
    output logic          last
);
    localparam int LW = AW + 1;

    logic          active;
    logic [AW-1:0] last_addr;

    assign we   = active;
    assign last = active && (addr == last_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active    <= 1'b1;
            addr      <= '0;
            last_addr <= AW'(INIT_LEN - 1);
        end else if (start) begin
            active    <= 1'b1;
            addr      <= start_addr;
            last_addr <= AW'(LW'(start_addr) + len - LW'(1));
        end else if (active) begin
            if (addr == last_addr) active <= 1'b0;
            else                   addr   <= addr + AW'(1);
        end
    end
endmodule

// File: rtl/vram_text_writer.sv
// Character-stream front end for the text display. Accepts bytes,
// decodes BS/LF/FF/CR, tracks the cursor and drives the VRAM write port.
//   clk, rst_n            : clock, async active-low reset
//   bus (slave)           : byte handshake in, VRAM write port out
//   cursor_col/cursor_row : current cursor position
//   busy                  : a line or screen clear is in progress
module vram_text_writer
    import vga_text_pkg::*;
#(
    parameter int         COLS  = COLS_DEF,
    parameter int         ROWS  = ROWS_DEF,
    parameter int         AW    = AW_DEF,
    parameter logic [7:0] BLANK = BLANK_CH
) (
    input  logic              clk,
    input  logic              rst_n,
    vram_text_writer_if.slave bus,
    output logic [5:0]        cursor_col,
    output logic [4:0]        cursor_row,
    output logic              busy
);
    localparam int         LW       = AW + 1;
    localparam logic [5:0] LAST_COL = 6'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    state_e        state, nxt_state;
    logic [AW-1:0] linebase, nxt_base;
    logic [5:0]    nxt_col;
    logic [4:0]    nxt_row;
    logic          accept, adv;
    logic          char_we;
    logic [AW-1:0] char_addr;
    logic [7:0]    char_data;
    logic          fill_start, fill_we, fill_last;
    logic [AW-1:0] fill_addr;
    logic [AW:0]   fill_len;

    assign accept = bus.in_valid && bus.in_ready;

    vram_fill_seq #(.AW(AW), .INIT_LEN(COLS * ROWS)) u_fill (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (fill_start),
        .start_addr (nxt_base),
        .len        (fill_len),
        .we         (fill_we),
        .addr       (fill_addr),
        .last       (fill_last)
    );

    always_comb begin
        nxt_state  = state;
        nxt_col    = cursor_col;
        nxt_row    = cursor_row;
        nxt_base   = linebase;
        adv        = 1'b0;
        char_we    = 1'b0;
        char_addr  = linebase + AW'(cursor_col);
        char_data  = bus.in_data;
        fill_start = 1'b0;
        fill_len   = LW'(COLS * ROWS);
        case (state)
            ST_IDLE: if (accept) begin
                if (is_printable(bus.in_data)) begin
                    char_we = 1'b1;
                    if (cursor_col == LAST_COL) adv = 1'b1;
                    else                        nxt_col = cursor_col + 6'd1;
                end else if (bus.in_data == CH_LF) begin
                    adv = 1'b1;
                end else if (bus.in_data == CH_CR) begin
                    nxt_col = '0;
                end else if (bus.in_data == CH_BS) begin
                    if (cursor_col != '0) begin
                        nxt_col   = cursor_col - 6'd1;
                        char_we   = 1'b1;
                        char_addr = linebase + AW'(cursor_col - 6'd1);
                        char_data = BLANK;
                    end
                end else if (bus.in_data == CH_FF) begin
                    nxt_state  = ST_CLR_SCREEN;
                    nxt_col    = '0;
                    nxt_row    = '0;
                    nxt_base   = '0;
                    fill_start = 1'b1;
                end
                // Row advance: no scrolling, the bottom row wraps to the top
                // and the freshly entered row is blanked.
                if (adv) begin
                    nxt_col    = '0;
                    nxt_state  = ST_CLR_LINE;
                    fill_start = 1'b1;
                    fill_len   = LW'(COLS);
                    if (cursor_row == LAST_ROW) begin
                        nxt_row  = '0;
                        nxt_base = '0;
                    end else begin
                        nxt_row  = cursor_row + 5'd1;
                        nxt_base = linebase + AW'(COLS);
                    end
                end
            end
            ST_CLR_SCREEN, ST_CLR_LINE: if (fill_last) nxt_state = ST_IDLE;
            default: nxt_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_CLR_SCREEN;
            cursor_col     <= '0;
            cursor_row     <= '0;
            linebase       <= '0;
            bus.vram_we    <= 1'b0;
            bus.vram_waddr <= '0;
            bus.vram_wdata <= BLANK;
            bus.in_ready   <= 1'b0;
            busy           <= 1'b1;
        end else begin
            state      <= nxt_state;
            cursor_col <= nxt_col;
            cursor_row <= nxt_row;
            linebase   <= nxt_base;
            // Ready only once the FSM has sat in IDLE for a full cycle, so
            // it drops on the accept edge of a byte that starts a clear and
            // rises the cycle after a clear's final write.
            bus.in_ready <= (state == ST_IDLE) && (nxt_state == ST_IDLE);
            busy         <= !((state == ST_IDLE) && (nxt_state == ST_IDLE));
            if (fill_we) begin
                bus.vram_we    <= 1'b1;
                bus.vram_waddr <= fill_addr;
                bus.vram_wdata <= BLANK;
            end else if (char_we) begin
                bus.vram_we    <= 1'b1;
                bus.vram_waddr <= char_addr;
                bus.vram_wdata <= char_data;
            end else begin
                bus.vram_we    <= 1'b0;
            end
        end
    end
endmodule

// File: doc/vram_text_writer.md
Name: vram_text_writer

Overview:
Character-stream front end for the 40x30 text VGA display. Accepts bytes over a valid/ready handshake, interprets a small set of control codes, tracks the cursor, and drives the display's VRAM write port (vram_waddr/vram_wdata/vram_we) directly. Sits between any byte source (UART RX, CPU register) and the text display; clears the screen itself after reset.

Parameters:
COLS, 40, characters per row
ROWS, 30, rows per screen
AW, 11, VRAM address width; COLS*ROWS must be at most 2**AW
BLANK, 8'h20, fill byte used for clears

Ports:
clk  in  1  system clock, same domain as the display (25 MHz)
rst_n  in  1  asynchronous active-low reset
in_data  in  8  byte to display or control code
in_valid  in  1  in_data valid
in_ready  out  1  block can accept a byte this cycle; transfer when in_valid&&in_ready
vram_waddr  out  AW  VRAM write address, row*COLS+col
vram_wdata  out  8  VRAM write data
vram_we  out  1  VRAM write strobe, one write per cycle when high
cursor_col  out  6  current column, 0..COLS-1
cursor_row  out  5  current row, 0..ROWS-1
busy  out  1  high while a clear sequence is running

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- All outputs are registered. Reset values: vram_we=0, vram_waddr=0, vram_wdata=BLANK, cursor 0/0, in_ready=0, busy=1. The FSM enters CLR_SCREEN on reset.
- FSM states: IDLE, CLR_SCREEN, CLR_LINE.
- IDLE: in_ready=1, busy=0. An accepted byte takes effect in the next cycle (latency 1).
  - 0x20..0x7E: next cycle vram_we=1, vram_waddr=cursor address, vram_wdata=byte. Then col++.
  - col==COLS-1 acts as a newline after the write.
  - 0x0A LF: col=0, row++.
  - 0x0D CR: col=0; no write.
  - 0x08 BS: if col>0, col-- and write BLANK at the new position. At col 0, no effect.
  - 0x0C FF: go to CLR_SCREEN and home the cursor.
  - Any other byte is consumed and ignored: no write, no cursor change.
- Row advance past ROWS-1 wraps row to 0. There is no scrolling. Any row advance, including a wrap, enters CLR_LINE for the new row.
- CLR_LINE: in_ready=0, busy=1. Writes BLANK to the COLS addresses of the new row, one per cycle, ascending. The cursor sits at col 0 of that row. Returns to IDLE the cycle after the last write.
- CLR_SCREEN: in_ready=0, busy=1. Writes BLANK to addresses 0..COLS*ROWS-1, one per cycle, ascending (1200 cycles with defaults). Then goes to IDLE with cursor 0/0.
- Address generation: keep a line-base register, updated by +COLS or reset to 0; no multiplier. vram_waddr = linebase + col, width AW, never exceeds COLS*ROWS-1.
- vram_we is high only in the cycle of a write. vram_waddr and vram_wdata hold their last values when vram_we is low.
- in_valid while in_ready=0 is not consumed; the source holds the byte. No input buffering.
- rst_n asserted mid-clear or mid-write aborts immediately. The full screen clear restarts after reset release.

Decomposition:
- Shared package vga_text_pkg: COLS/ROWS/AW defaults, BLANK, control-code constants (CH_BS=8'h08, CH_LF=8'h0A, CH_FF=8'h0C, CH_CR=8'h0D), FSM state encoding.
- Sub-module vram_fill_seq: counter plus write-strobe generator for a start address and length. Used for both clears.
- Cursor and command decode stay in the top module.

Test Plan:
- Release reset, in_valid=0 -> exactly 1200 writes of 0x20 to addresses 0..1199 in consecutive cycles. Then in_ready=1, busy=0, cursor 0/0.
- After init, send "AB" -> writes 0x41@0 and 0x42@1, each one cycle after acceptance; cursor_col=2.
- Send 40 printable bytes from col 0 of row 0 -> last write at address 39. Then 40 BLANK writes at 40..79 with in_ready=0; cursor 0/1.
- Position the cursor at row 29 and send LF -> row wraps to 0. BLANK written to 0..39; cursor 0/0.
- At col 5, row 2: send BS -> write 0x20@84, cursor_col=4. Send CR -> no write, col=0. Send BS at col 0 -> no write.
- Assert rst_n low during a CLR_LINE -> vram_we drops immediately. On release, the full 1200-write clear restarts from address 0.
